// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect handling.
// Holds one instruction for the decoder. A response that belongs to a request
// abandoned by a redirect is swallowed in DROP.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap redirects whose
// target is not word aligned (FAULT state, misaligned output). Without it
// the target's low two bits are cleared and the misaligned port does not exist.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    S_FAULT
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_tgt;
  logic fault_pend_q;
  logic pend_now;
  assign tgt     = redirect_pc;
  assign mis_tgt = |redirect_pc[1:0];
  // A request is still in flight if memory took it this cycle or a response
  // we were waiting for has not shown up yet.
  assign pend_now = (state_q == S_FAULT) ? (fault_pend_q && !imem_rsp_valid)
                  : ((state_q == S_REQ) && imem_req_ready) ||
                    (((state_q == S_WAIT) || (state_q == S_DROP)) && !imem_rsp_valid);
`else
  assign tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  // Next-state: normal flow first, redirect overrides it
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_REQ;
      S_REQ:   if (imem_req_ready) state_d = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_d = S_HOLD;
      S_HOLD:  if (instr_ready)    state_d = S_REQ;
      S_DROP:  if (imem_rsp_valid) state_d = S_REQ;
      default: state_d = state_q;
    endcase
    if (redirect_valid) begin
      case (state_q)
        S_BOOT:  state_d = S_REQ;
        S_REQ:   state_d = imem_req_ready ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        S_HOLD:  state_d = S_REQ;
        S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
`ifdef FETCH_MISALIGN_TRAP_EN
        S_FAULT: state_d = (fault_pend_q && !imem_rsp_valid) ? S_DROP : S_REQ;
`endif
        default: state_d = S_REQ;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      if (mis_tgt) state_d = S_FAULT;
`endif
    end
  end

  // Outputs decoded from state; request address is always the current pc
  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    imem_req_addr  = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned     = (state_q == S_FAULT);
`endif
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Remember an in-flight request across FAULT so leaving FAULT can still drop it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 fault_pend_q <= 1'b0;
    else if (state_d == S_FAULT) fault_pend_q <= pend_now;
    else                        fault_pend_q <= 1'b0;
  end
`endif

  // pc and decoder-facing registers; redirect wins over capture and handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
    end else if (redirect_valid) begin
      pc_q        <= tgt;
      instr_valid <= 1'b0;
    end else begin
      if ((state_q == S_WAIT) && imem_rsp_valid) begin
        instr       <= imem_rsp_data;
        instr_pc    <= pc_q;
        instr_valid <= 1'b1;
        pc_q        <= pc_q + 32'd4;   // wraps naturally at 2^32
      end else if ((state_q == S_HOLD) && instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: imem_req_valid  output  1  instruction-memory read request valid.
REQ-005 Port: imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 Port: imem_req_addr  output  32  request byte address (current PC).
REQ-007 Port: imem_rsp_valid  input  1  read data valid.
REQ-008 Port: imem_rsp_data  input  32  fetched instruction word.
REQ-009 Port: instr_valid  output  1  instruction presented to decoder.
REQ-010 Port: instr_ready  input  1  decoder stage consumes instruction.
REQ-011 Port: instr  output  32  instruction word to decoder.
REQ-012 Port: instr_pc  output  32  address of presented instruction.
REQ-013 Port: redirect_valid  input  1  branch/jump redirect from execute.
REQ-014 Port: redirect_pc  input  32  redirect target.
REQ-015 Port: misaligned  output  1  misaligned-target fault (FETCH_MISALIGN_TRAP_EN only).

Function
REQ-016 States: BOOT, REQ, WAIT, HOLD, DROP (plus FAULT with macro); at most one memory request outstanding.
REQ-017 BOOT: no request; unconditionally -> REQ on first edge after rst_n deasserts.
REQ-018 REQ: imem_req_valid=1, imem_req_addr=pc; req_ready=1 -> WAIT; else stay, addr stable.
REQ-019 WAIT: rsp_valid=1 -> instr<=rsp_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4, -> HOLD.
REQ-020 HOLD: instr/instr_pc/instr_valid held stable; instr_valid&&instr_ready -> instr_valid<=0, -> REQ.
REQ-021 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 Latency: request issued in REQ reaches instr_valid one cycle after rsp_valid; 0-wait memory gives one instruction per 3 cycles.
REQ-023 redirect_valid has priority over every other event; pc<=redirect_pc, instr_valid<=0 next cycle.
REQ-024 Redirect in REQ without req_ready -> stay REQ, new address next cycle.
REQ-025 Redirect in REQ with req_ready, or in WAIT without rsp_valid -> DROP (stale response pending).
REQ-026 Redirect in WAIT with rsp_valid -> response discarded, -> REQ.
REQ-027 Redirect in HOLD -> REQ; a same-cycle instr_valid&&instr_ready is not a transfer.
REQ-028 DROP: no request; next rsp_valid discarded -> REQ; redirect in DROP updates pc, stays DROP unless rsp_valid same cycle (-> REQ).
REQ-029 imem_rsp_valid outside WAIT/DROP is ignored.

Reset
REQ-030 rst_n low asynchronously forces: state=BOOT, pc=RESET_PC, imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, misaligned=0.
REQ-031 Reset mid-transaction abandons outstanding request; response arriving after reset (in BOOT/REQ) ignored per REQ-029.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 -> FAULT, misaligned=1, no requests; aligned redirect leaves FAULT (-> REQ, misaligned<=0); pending response discarded as in DROP.
REQ-033 Macro undefined: misaligned port absent; redirect_pc[1:0] forced to 2'b00, FAULT state absent.

Verification
REQ-034 Reset release, RESET_PC=0, req_ready=1, 0-wait memory returning 32'h0010_0093 -> imem_req_addr 0x0, instr=32'h0010_0093, instr_pc=0x0, then addr 0x4.
REQ-035 instr_ready=0 for 5 cycles after instr_valid -> instr/instr_pc stable, no new request; instr_ready=1 -> next request addr 0x4.
REQ-036 Redirect to 0x100 in WAIT, stale response 32'hDEAD_BEEF two cycles later -> never presented; next request addr 0x100.
REQ-037 pc=0xFFFF_FFFC fetch completes -> next request addr 0x0000_0000.
REQ-038 rst_n pulsed low during WAIT -> instr_valid=0 immediately, first post-reset request addr RESET_PC.
REQ-039 Macro on: redirect to 0x102 -> misaligned=1, imem_req_valid=0; redirect to 0x200 -> misaligned=0, request addr 0x200.
